// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array block sequencer and its wrapper:
// sequencer state encoding and the positions of the in-band block tags.
package sa_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  // Tag positions are counted down from the word MSB: bit (DATA_WIDTH - ofs).
  localparam int EOB_OFS = 1;
  localparam int SOB_OFS = 2;

endpackage

// File: rtl/sa_credit_counter.sv
// Credit pool for the downstream result FIFO: tracks entries promised to
// in-flight blocks and flags a release that arrives with nothing outstanding.
module sa_credit_counter #(
  parameter int FIFO_DEPTH = 1024,
  parameter int N          = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              reserve,
  input  logic                              rel,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   used,
  output logic                              can_reserve,
  output logic                              underflow
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [31:0] used_w;

  assign used_w      = 32'(used);
  assign can_reserve = (used_w + 32'(N)) <= 32'(FIFO_DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used      <= '0;
      underflow <= 1'b0;
    end else begin
      unique case ({reserve, rel})
        2'b11: used <= used + CW'(N - 1);
        2'b10: used <= used + CW'(N);
        2'b01: begin
          // Release with nothing outstanding: clamp at zero, latch the error.
          if (used == '0) underflow <= 1'b1;
          else            used      <= used - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sa_block_sequencer.sv
// Feeds DMA words to the systolic-array wrapper one block at a time, tagging
// SOB/EOB in-band and only starting a block once its N result slots are reserved.
module sa_block_sequencer
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = 1024,
  parameter int N          = 8,
  parameter int FIFO_DEPTH = 1024,
  parameter int KW         = 16,
  parameter int BW         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [KW-1:0]         cfg_k,
  input  logic [BW-1:0]         cfg_num_blocks,
  output logic                  busy,
  output logic                  done,
  output logic                  err_underflow,
  input  logic                  s_rts_i,
  output logic                  s_rtr_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_rts_o,
  input  logic                  m_rtr_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  res_beat_i
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  seq_state_t      state, state_nxt;
  logic [KW-1:0]   k_q, beat_q;
  logic [BW-1:0]   nb_q, blk_q;
  logic [CW-1:0]   used;
  logic            rsv, can_rsv, hs, last_beat, last_blk, start;

  sa_credit_counter #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .N          (N)
  ) u_credit (
    .clk         (clk),
    .rst         (rst),
    .reserve     (rsv),
    .rel         (res_beat_i),
    .used        (used),
    .can_reserve (can_rsv),
    .underflow   (err_underflow)
  );

  assign start     = (state == S_IDLE) && cfg_start;
  assign hs        = (state == S_STREAM) && s_rts_i && m_rtr_i;
  assign last_beat = beat_q == (k_q - KW'(1));
  assign last_blk  = blk_q == (nb_q - BW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rsv       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cfg_start)
          state_nxt = (cfg_k == '0 || cfg_num_blocks == '0) ? S_DONE : S_ARM;
      end
      S_ARM: begin
        if (can_rsv) begin
          rsv       = 1'b1;
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (hs && last_beat) state_nxt = last_blk ? S_DRAIN : S_ARM;
      end
      S_DRAIN: begin
        if (used == '0) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q    <= '0;
      nb_q   <= '0;
      beat_q <= '0;
      blk_q  <= '0;
    end else if (start) begin
      k_q    <= cfg_k;
      nb_q   <= cfg_num_blocks;
      beat_q <= '0;
      blk_q  <= '0;
    end else if (hs) begin
      if (last_beat) begin
        beat_q <= '0;
        blk_q  <= blk_q + BW'(1);
      end else begin
        beat_q <= beat_q + KW'(1);
      end
    end
  end

  assign busy    = (state == S_ARM) || (state == S_STREAM) || (state == S_DRAIN);
  assign done    = (state == S_DONE);
  assign s_rtr_o = (state == S_STREAM) && m_rtr_i;
  assign m_rts_o = (state == S_STREAM) && s_rts_i;

  // Tags derive from the beat index alone, so they hold steady across stalls.
  always_comb begin
    m_data_o                        = s_data_i;
    m_data_o[DATA_WIDTH - SOB_OFS]  = (beat_q == '0);
    m_data_o[DATA_WIDTH - EOB_OFS]  = last_beat;
  end

endmodule
